// File: rtl/uart_rx_pkg.sv
// Register map, bit positions and FIFO geometry shared by the APB UART receive controller.
package uart_rx_pkg;

    localparam int unsigned FifoDepth = 8;
    localparam int unsigned FifoWidth = 8;

    localparam logic [3:0] AddrCtrl   = 4'h0;
    localparam logic [3:0] AddrStatus = 4'h4;
    localparam logic [3:0] AddrData   = 4'h8;
    localparam logic [3:0] AddrTout   = 4'hC;

    localparam int unsigned CtrlFlush = 6;

    localparam int unsigned StEmpty    = 0;
    localparam int unsigned StFull     = 1;
    localparam int unsigned StOverrun  = 2;
    localparam int unsigned StFrameErr = 3;
    localparam int unsigned StTimeout  = 4;

    // Stored CTRL bits [5:0]; rx_en sits at bit 0.
    typedef struct packed {
        logic       irq_en;
        logic [1:0] len;
        logic       stop2;
        logic       parity;
        logic       rx_en;
    } ctrl_t;

    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return 4'd5 + {2'b00, len};
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned Depth = FifoDepth,
    parameter int unsigned Width = FifoWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrW'(1);
            if (do_pop)  rptr_d = rptr_q + PtrW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// APB register front-end for the UART receiver: configuration, status, receive FIFO, idle timeout.
module uart_rx_ctrl
    import uart_rx_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [3:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    input  logic       baud_tick,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       error_rx_detect,
    output logic       RXen,
    output logic       parity_bit_mode,
    output logic       stop_bit_twice,
    output logic [3:0] number_data_receive,
    output logic       irq
);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    ctrl_t          ctrl_q, ctrl_d;
    logic [7:0]     tout_q, tout_d, idle_q, idle_d, prdata_q, prdata_d, rd_mux, status;
    logic           overrun_q, overrun_d, frame_q, frame_d, timeout_q, timeout_d;
    logic           irq_q, irq_d, pop_pend_q, pop_pend_d;
    logic           apb_setup, wr_en, flush, pop, push_acc, overrun_set, timeout_hit;
    logic [2:0]     w1c;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_head;
    logic [CntW-1:0] fifo_count;

    assign apb_setup = PSEL & ~PENABLE;
    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign flush     = wr_en & (PADDR == AddrCtrl) & PWDATA[CtrlFlush];
    assign w1c       = (wr_en && PADDR == AddrStatus) ? PWDATA[StTimeout:StOverrun] : 3'b000;
    // PRDATA is captured in the setup phase; the pop lands on the access edge.
    assign pop       = PSEL & PENABLE & ~PWRITE & pop_pend_q;
    assign push_acc  = rx_done & ~flush & ((fifo_count != CntW'(FifoDepth)) | pop);
    assign overrun_set = rx_done & ~flush & fifo_full & ~pop;
    assign timeout_hit = (tout_q != 8'd0) && (idle_q == tout_q);

    rx_fifo #(
        .Depth(FifoDepth),
        .Width(FifoWidth)
    ) u_rx_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .flush_i (flush),
        .push_i  (rx_done),
        .wdata_i (rx_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status             = '0;
        status[StEmpty]    = fifo_empty;
        status[StFull]     = fifo_full;
        status[StOverrun]  = overrun_q;
        status[StFrameErr] = frame_q;
        status[StTimeout]  = timeout_q;
        case (PADDR)
            AddrCtrl:   rd_mux = {2'b00, ctrl_q};
            AddrStatus: rd_mux = status;
            AddrData:   rd_mux = fifo_empty ? 8'h00 : fifo_head;
            AddrTout:   rd_mux = tout_q;
            default:    rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        tout_d     = tout_q;
        prdata_d   = prdata_q;
        pop_pend_d = 1'b0;
        if (wr_en && PADDR == AddrCtrl) ctrl_d = ctrl_t'(PWDATA[5:0]);
        if (wr_en && PADDR == AddrTout) tout_d = PWDATA;
        if (apb_setup && !PWRITE) begin
            prdata_d   = rd_mux;
            pop_pend_d = (PADDR == AddrData) & ~fifo_empty;
        end
        // Sticky bits: a same-cycle event wins over its write-1-to-clear.
        overrun_d = (overrun_q & ~w1c[0]) | overrun_set;
        frame_d   = (frame_q & ~w1c[1]) | error_rx_detect;
        timeout_d = (timeout_q & ~w1c[2]) | timeout_hit;
        idle_d    = idle_q;
        if (flush || push_acc || pop || fifo_empty) begin
            idle_d = 8'd0;
        end else if (ctrl_q.rx_en && baud_tick && !timeout_hit) begin
            idle_d = idle_q + 8'd1;
        end
        irq_d = ctrl_q.irq_en & (~fifo_empty | overrun_q | frame_q | timeout_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q     <= '0;
            tout_q     <= '0;
            idle_q     <= '0;
            prdata_q   <= '0;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
            timeout_q  <= 1'b0;
            irq_q      <= 1'b0;
            pop_pend_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tout_q     <= tout_d;
            idle_q     <= idle_d;
            prdata_q   <= prdata_d;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
            timeout_q  <= timeout_d;
            irq_q      <= irq_d;
            pop_pend_q <= pop_pend_d;
        end
    end

    assign PRDATA              = prdata_q;
    assign PREADY              = 1'b1;
    assign RXen                = ctrl_q.rx_en;
    assign parity_bit_mode     = ctrl_q.parity;
    assign stop_bit_twice      = ctrl_q.stop2;
    assign number_data_receive = data_bits(ctrl_q.len);
    assign irq                 = irq_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port PCLK  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-004 SHALL have ports PADDR  input  4 and PWDATA  input  8: APB address and write data.
REQ-005 SHALL have ports PRDATA  output  8 and PREADY  output  1: APB read data and ready.
REQ-006 SHALL have port baud_tick  input  1  one-PCLK strobe per bit period.
REQ-007 SHALL have ports rx_done  input  1 and rx_data  input  8: frame-complete strobe and received byte.
REQ-008 SHALL have port error_rx_detect  input  1  frame/parity error strobe from RX FSM.
REQ-009 SHALL have ports RXen, parity_bit_mode, stop_bit_twice  output  1 each: RX FSM configuration.
REQ-010 SHALL have port number_data_receive  output  4  data bits per frame, 5..8.
REQ-011 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-012 SHALL drive PREADY=1 constantly; zero wait states; a write commits on the PCLK edge where PSEL&PENABLE&PWRITE.
REQ-013 SHALL implement CTRL at 0x0: bit0 RXen, bit1 parity_bit_mode, bit2 stop_bit_twice, bits4:3 len (number_data_receive = 5+len), bit5 irq_en, bit6 flush (write-only, self-clearing, reads 0).
REQ-014 SHALL implement STATUS at 0x4: bit0 empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 timeout; bits2-4 sticky, write-1-to-clear; bits0-1 read-only.
REQ-015 SHALL implement DATA at 0x8: read returns FIFO head and pops one entry; read when empty returns 0x00 and does not pop; writes ignored.
REQ-016 SHALL implement TOUT at 0xC: 8-bit threshold in baud ticks; 0 disables timeout.
REQ-017 SHALL return 0x00 on reads of unmapped addresses and ignore unmapped writes.
REQ-018 SHALL buffer bytes in an 8-entry x 8-bit FIFO; rx_done pushes rx_data; empty deasserts the cycle after the push.
REQ-019 SHALL discard rx_data and set overrun when rx_done arrives while full, unless a DATA pop occurs in the same cycle, in which case pop and push both happen and count stays 8.
REQ-020 SHALL perform push and pop in the same cycle on a non-empty, non-full FIFO with count unchanged; pointers wrap modulo 8.
REQ-021 SHALL set frame_err on error_rx_detect; a simultaneous STATUS W1C of that bit leaves it set (set wins).
REQ-022 SHALL count baud_tick in an 8-bit idle counter while RXen=1 and FIFO non-empty; clear it on push, pop, or empty; set timeout when counter equals nonzero TOUT, then hold the counter.
REQ-023 SHALL on flush reset FIFO pointers and count and the idle counter in one cycle; a same-cycle rx_done is discarded without setting overrun.
REQ-024 SHALL drive irq next cycle as irq_en & (!empty | overrun | frame_err | timeout).
REQ-025 SHALL leave FIFO contents intact when RXen is cleared; pushes still accepted.

Reset
REQ-026 SHALL on PRESETn=0 immediately force: CTRL=0x00 (RXen=0, parity_bit_mode=0, stop_bit_twice=0, number_data_receive=5, irq=0), TOUT=0, FIFO empty, pointers 0, sticky bits 0, idle counter 0, PRDATA=0.
REQ-027 SHALL discard any in-flight access or rx_done on reset assertion mid-operation; no partial FIFO state survives.

Structure
REQ-028 SHALL place register addresses, CTRL/STATUS bit positions, FIFO depth and width in package uart_rx_pkg.
REQ-029 SHALL instantiate one sub-module rx_fifo (synchronous FIFO with push/pop/full/empty/count) for storage.

Verification
REQ-030 SHALL cover: write CTRL=0x1B -> RXen=1, parity_bit_mode=1, stop_bit_twice=0, number_data_receive=8.
REQ-031 SHALL cover: push 0x11,0x22,0x33, read DATA x4 -> 0x11,0x22,0x33,0x00; STATUS bit0=1 afterward.
REQ-032 SHALL cover: 9 rx_done with no reads -> full=1, overrun=1, first 8 bytes read in order; W1C 0x04 clears overrun.
REQ-033 SHALL cover: TOUT=4, one byte pushed, 4 baud_ticks -> timeout=1 and irq=1 (irq_en=1); TOUT=0 variant -> timeout stays 0.
REQ-034 SHALL cover: FIFO full, DATA read concurrent with rx_done -> count 8, overrun=0, new byte last in order.
REQ-035 SHALL cover: PRESETn pulse with 5 bytes buffered -> empty=1, CTRL=0x00, irq=0 without waiting for a clock edge.
